// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle for axil_cmd_master: master drives AW/W/AR and the B/R ready signals,
// slave drives the opposite direction.
interface axil_cmd_master_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] M_AXI_AWADDR;
    logic              M_AXI_AWVALID;
    logic              M_AXI_AWREADY;
    logic [31:0]       M_AXI_WDATA;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_WVALID;
    logic              M_AXI_WREADY;
    logic [1:0]        M_AXI_BRESP;
    logic              M_AXI_BVALID;
    logic              M_AXI_BREADY;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [31:0]       M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding command-to-AXI4-Lite master: one command in, one AXI transaction, one response.
// Define AXIL_CMD_MASTER_WSTRB_EN to add a cmd_wstrb input; otherwise writes use full strobes.
module axil_cmd_master #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
`ifdef AXIL_CMD_MASTER_WSTRB_EN
    input  logic [3:0]        cmd_wstrb,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    axil_cmd_master_if.master m_axi
);

    typedef enum logic [2:0] {
        StIdle,
        StWaddr,
        StWresp,
        StRaddr,
        StRdata,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [3:0]        wstrb_val;

    logic awvalid, wvalid, bready, arvalid, rready;
    logic aw_hs, w_hs;

`ifdef AXIL_CMD_MASTER_WSTRB_EN
    logic [3:0] wstrb_q, wstrb_d;
    assign wstrb_val = wstrb_q;
`else
    assign wstrb_val = 4'hF;
`endif

    // Only RESP[1] distinguishes OKAY/EXOKAY from SLVERR/DECERR.
    logic unused_resp;
    assign unused_resp = m_axi.M_AXI_BRESP[0] ^ m_axi.M_AXI_RRESP[0];

    assign aw_hs = awvalid && m_axi.M_AXI_AWREADY;
    assign w_hs  = wvalid && m_axi.M_AXI_WREADY;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
`ifdef AXIL_CMD_MASTER_WSTRB_EN
        wstrb_d   = wstrb_q;
`endif
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rsp_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Reset overrides acceptance, so keep ready low while rst is held.
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
`ifdef AXIL_CMD_MASTER_WSTRB_EN
                    wstrb_d   = cmd_wstrb;
`endif
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? StWaddr : StRaddr;
                end
            end
            StWaddr: begin
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = StWresp;
                end
            end
            StWresp: begin
                bready = 1'b1;
                if (m_axi.M_AXI_BVALID) begin
                    err_d   = m_axi.M_AXI_BRESP[1];
                    rdata_d = '0;
                    state_d = StResp;
                end
            end
            StRaddr: begin
                arvalid = 1'b1;
                if (m_axi.M_AXI_ARREADY) begin
                    state_d = StRdata;
                end
            end
            StRdata: begin
                rready = 1'b1;
                if (m_axi.M_AXI_RVALID) begin
                    rdata_d = m_axi.M_AXI_RDATA;
                    err_d   = m_axi.M_AXI_RRESP[1];
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef AXIL_CMD_MASTER_WSTRB_EN
            wstrb_q   <= 4'h0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
`ifdef AXIL_CMD_MASTER_WSTRB_EN
            wstrb_q   <= wstrb_d;
`endif
        end
    end

    // Buses are zeroed whenever their VALID is low so idle bus values never leak stale data.
    always_comb begin
        m_axi.M_AXI_AWVALID = awvalid;
        m_axi.M_AXI_AWADDR  = awvalid ? addr_q : '0;
        m_axi.M_AXI_WVALID  = wvalid;
        m_axi.M_AXI_WDATA   = wvalid ? wdata_q : 32'h0;
        m_axi.M_AXI_WSTRB   = wvalid ? wstrb_val : 4'h0;
        m_axi.M_AXI_BREADY  = bready;
        m_axi.M_AXI_ARVALID = arvalid;
        m_axi.M_AXI_ARADDR  = arvalid ? addr_q : '0;
        m_axi.M_AXI_RREADY  = rready;
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of cmd_addr and the AXI address buses.
REQ-002 SHALL have port clk, input, 1: single clock for all logic.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port cmd_valid, input, 1: command request.
REQ-005 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid & cmd_ready.
REQ-006 SHALL have port cmd_write, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have ports cmd_addr (input, ADDR_W) and cmd_wdata (input, 32): command address and write data.
REQ-008 SHALL have port rsp_valid, output, 1: response available.
REQ-009 SHALL have port rsp_ready, input, 1: response consumed when rsp_valid & rsp_ready.
REQ-010 SHALL have ports rsp_rdata (output, 32; read data, 0 for writes) and rsp_err (output, 1; RESP[1] of the completed transaction).
REQ-011 SHALL have AXI4-Lite master ports M_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY, with standard directions and widths (addresses ADDR_W, data 32, strobe 4, resp 2).

Function
REQ-012 SHALL implement states IDLE, WADDR, WRESP, RADDR, RDATA, RESP.
REQ-013 SHALL drive cmd_ready = 1 only in IDLE.
REQ-014 SHALL, on accepting a command, register cmd_addr, cmd_wdata and cmd_write, then enter WADDR (write) or RADDR (read).
REQ-015 SHALL, in WADDR, assert AWVALID and WVALID together on the first cycle after acceptance.
REQ-016 SHALL deassert each of AWVALID and WVALID independently in the cycle after its own handshake.
REQ-017 SHALL record each handshake in an aw_done / w_done flag, and enter WRESP once both flags are set, including when both handshakes occur in the same cycle.
REQ-018 SHALL hold AWADDR, WDATA and WSTRB stable while their VALID is high.
REQ-019 SHALL, in WRESP, assert BREADY = 1; on the BVALID handshake, capture BRESP, set rdata = 0 and enter RESP.
REQ-020 SHALL, in RADDR, assert ARVALID until the ARREADY handshake, then enter RDATA.
REQ-021 SHALL, in RDATA, assert RREADY = 1; on the RVALID handshake, capture RDATA and RRESP and enter RESP.
REQ-022 SHALL, in RESP, hold rsp_valid = 1 with stable rsp_rdata and rsp_err until rsp_ready, then return to IDLE.
REQ-023 SHALL allow no new command to be accepted in the same cycle as the response handshake (one idle cycle minimum between transactions).
REQ-024 SHALL give best-case write latency of acceptance at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2 and rsp_valid at cycle 3; reads follow the same pattern with AR and R.
REQ-025 SHALL leave the AXI VALID signals unaffected by cmd_valid outside IDLE, and ignore BVALID or RVALID arriving in states where they are not expected.
REQ-026 SHALL drive address and data buses to 0 when their VALID is low.

Reset
REQ-027 SHALL, while rst is high at a clock edge, force state to IDLE and clear all VALID/READY outputs, rsp_valid, rsp_rdata, rsp_err and the aw_done/w_done flags.
REQ-028 SHALL, on reset mid-transaction, abandon the transaction with no response issued; cmd_ready SHALL be 1 in the first cycle after rst falls.

Configuration
REQ-029 SHALL, with macro AXIL_CMD_MASTER_WSTRB_EN defined, add input cmd_wstrb [3:0], registered at acceptance and driven on M_AXI_WSTRB.
REQ-030 SHALL, without AXIL_CMD_MASTER_WSTRB_EN, omit cmd_wstrb and drive M_AXI_WSTRB = 4'hF during WVALID.

Verification
REQ-031 SHALL verify a zero-wait write: write addr 0x10 data 0x00000005 to a slave with AW/W/B ready immediately -> AWADDR = 0x10, WDATA = 5 at cycle 1; rsp_valid at cycle 3 with rsp_err = 0 and rsp_rdata = 0.
REQ-032 SHALL verify a split write: AWREADY in cycle 1, WREADY delayed to cycle 4 -> AWVALID low from cycle 2; WVALID high through cycle 4; exactly one B handshake; one response.
REQ-033 SHALL verify a read: read 0x00 with the slave returning RDATA = 0xDEADBEEF, RRESP = 0 after 2 wait cycles -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, held until rsp_ready.
REQ-034 SHALL verify an error path: BRESP = 2'b10 -> rsp_err = 1; RRESP = 2'b11 on a read -> rsp_err = 1.
REQ-035 SHALL verify reset mid-write: rst asserted while in WRESP -> all VALIDs and rsp_valid are 0 the next cycle; cmd_ready = 1 after release; no response is produced.
REQ-036 SHALL verify backpressure: rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready = 0 throughout; with WSTRB_EN defined and cmd_wstrb = 4'h3, WSTRB = 4'h3.
